// File: rtl/fft_bfly_r2.sv
// Radix-2 DIT butterfly: X0 = a + W*b, X1 = a - W*b, optional /2 scaling and conj(W).
// Latency: 3 cycles (input reg, complex multiply, add/sub/scale/range-reduce), 1 sample/cycle.
// Backpressure: whole pipe freezes when out_valid & !out_ready; in_ready = !out_valid | out_ready.
// Build option: define FFT_BFLY_SAT_EN to saturate out-of-range results instead of wrapping.
module fft_bfly_r2 #(
  parameter int DW = 16,
  parameter int TW = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 scale,
  input  logic                 inverse,
  input  logic signed [DW-1:0] a_re,
  input  logic signed [DW-1:0] a_im,
  input  logic signed [DW-1:0] b_re,
  input  logic signed [DW-1:0] b_im,
  input  logic signed [TW-1:0] w_re,
  input  logic signed [TW-1:0] w_im,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [DW-1:0] X0_re,
  output logic signed [DW-1:0] X0_im,
  output logic signed [DW-1:0] X1_re,
  output logic signed [DW-1:0] X1_im,
  output logic                 ovf
);

  // PW holds the full cross-product sum without overflow; SW holds a +/- p.
  localparam int PW = DW + TW + 2;
  localparam int SW = DW + 2;
  localparam logic signed [PW-1:0] RND = PW'(1) << (TW - 2);
  localparam logic signed [SW-1:0] ONE = SW'(1);

  logic w_en;
  assign w_en     = !out_valid || out_ready;
  assign in_ready = w_en;

  // Conjugation happens on a TW+1 bit copy so that negating -1.0 stays exact.
  logic signed [TW:0] w_wi_ext;
  logic signed [TW:0] w_wi_sel;
  assign w_wi_ext = {w_im[TW-1], w_im};
  assign w_wi_sel = inverse ? -w_wi_ext : w_wi_ext;

  logic                 r1_vld, r1_scale;
  logic signed [DW-1:0] r1_a_re, r1_a_im, r1_b_re, r1_b_im;
  logic signed [TW:0]   r1_w_re, r1_w_im;

  // Stage 1: capture operands, twiddle (already conjugated) and scale flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r1_vld   <= 1'b0;
      r1_scale <= 1'b0;
      r1_a_re  <= '0;
      r1_a_im  <= '0;
      r1_b_re  <= '0;
      r1_b_im  <= '0;
      r1_w_re  <= '0;
      r1_w_im  <= '0;
    end else if (w_en) begin
      r1_vld   <= in_valid;
      r1_scale <= scale;
      r1_a_re  <= a_re;
      r1_a_im  <= a_im;
      r1_b_re  <= b_re;
      r1_b_im  <= b_im;
      r1_w_re  <= {w_re[TW-1], w_re};
      r1_w_im  <= w_wi_sel;
    end
  end

  // Full-width complex multiply with round-half-up back to Q(TW-1).
  logic signed [PW-1:0] w_acc_re, w_acc_im;
  logic signed [SW-1:0] w_p_re, w_p_im;
  assign w_acc_re = PW'(r1_b_re) * PW'(r1_w_re) - PW'(r1_b_im) * PW'(r1_w_im) + RND;
  assign w_acc_im = PW'(r1_b_re) * PW'(r1_w_im) + PW'(r1_b_im) * PW'(r1_w_re) + RND;
  assign w_p_re   = SW'(w_acc_re >>> (TW - 1));
  assign w_p_im   = SW'(w_acc_im >>> (TW - 1));

  logic                 r2_vld, r2_scale;
  logic signed [DW-1:0] r2_a_re, r2_a_im;
  logic signed [SW-1:0] r2_p_re, r2_p_im;

  // Stage 2: register the product W*b alongside the delayed a operand.
  always_ff @(posedge clk) begin
    if (rst) begin
      r2_vld   <= 1'b0;
      r2_scale <= 1'b0;
      r2_a_re  <= '0;
      r2_a_im  <= '0;
      r2_p_re  <= '0;
      r2_p_im  <= '0;
    end else if (w_en) begin
      r2_vld   <= r1_vld;
      r2_scale <= r1_scale;
      r2_a_re  <= r1_a_re;
      r2_a_im  <= r1_a_im;
      r2_p_re  <= w_p_re;
      r2_p_im  <= w_p_im;
    end
  end

  // Optional halving, then reduction to DW bits; bit DW of the result flags overflow.
  function automatic logic [DW:0] f_reduce(input logic signed [SW-1:0] s, input logic sc);
    logic signed [SW-1:0] v;
    logic                 ov;
    logic [DW-1:0]        r;
    v  = sc ? ((s + ONE) >>> 1) : s;
    ov = (v[SW-1:DW-1] != {(SW-DW+1){v[SW-1]}});
`ifdef FFT_BFLY_SAT_EN
    if (!ov)          r = v[DW-1:0];
    else if (v[SW-1]) r = {1'b1, {(DW-1){1'b0}}};
    else              r = {1'b0, {(DW-1){1'b1}}};
`else
    r = v[DW-1:0];
`endif
    return {ov, r};
  endfunction

  logic signed [SW-1:0] w_s0_re, w_s0_im, w_s1_re, w_s1_im;
  logic [DW:0]          w_r0_re, w_r0_im, w_r1_re, w_r1_im;
  logic                 w_any_ovf;
  assign w_s0_re   = SW'(r2_a_re) + r2_p_re;
  assign w_s0_im   = SW'(r2_a_im) + r2_p_im;
  assign w_s1_re   = SW'(r2_a_re) - r2_p_re;
  assign w_s1_im   = SW'(r2_a_im) - r2_p_im;
  assign w_r0_re   = f_reduce(w_s0_re, r2_scale);
  assign w_r0_im   = f_reduce(w_s0_im, r2_scale);
  assign w_r1_re   = f_reduce(w_s1_re, r2_scale);
  assign w_r1_im   = f_reduce(w_s1_im, r2_scale);
  assign w_any_ovf = w_r0_re[DW] | w_r0_im[DW] | w_r1_re[DW] | w_r1_im[DW];

  // Stage 3: output register; results hold while stalled, ovf is sticky until reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      X0_re     <= '0;
      X0_im     <= '0;
      X1_re     <= '0;
      X1_im     <= '0;
      ovf       <= 1'b0;
    end else if (w_en) begin
      out_valid <= r2_vld;
      if (r2_vld) begin
        X0_re <= w_r0_re[DW-1:0];
        X0_im <= w_r0_im[DW-1:0];
        X1_re <= w_r1_re[DW-1:0];
        X1_im <= w_r1_im[DW-1:0];
        ovf   <= ovf | w_any_ovf;
      end
    end
  end

endmodule

// File: tb/tb_fft_bfly_r2.sv
// Directed bench for fft_bfly_r2 (DW = TW = 16): vector table, streaming with a stall,
// sticky overflow and mid-flight reset sequences.
module tb_fft_bfly_r2;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid, in_ready, scale, inverse;
  logic signed [15:0] a_re, a_im, b_re, b_im, w_re, w_im;
  logic               out_valid, out_ready, ovf;
  logic signed [15:0] X0_re, X0_im, X1_re, X1_im;

  fft_bfly_r2 #(.DW(16), .TW(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .scale(scale), .inverse(inverse),
    .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im),
    .out_valid(out_valid), .out_ready(out_ready),
    .X0_re(X0_re), .X0_im(X0_im), .X1_re(X1_re), .X1_im(X1_im),
    .ovf(ovf)
  );

  always #5 clk = ~clk;

`ifdef FFT_BFLY_SAT_EN
  localparam int POS_X1 = 32767;
  localparam int NEG_X1 = -32768;
`else
  localparam int POS_X1 = -2;
  localparam int NEG_X1 = 0;
`endif

  typedef struct {
    string name;
    int    ar, ai, br, bi, wr, wi;
    bit    sc, inv;
    int    x0r, x0i, x1r, x1i;
    bit    ov;
  } vec_t;

  vec_t vecs [9];
  int   n_chk = 0;
  int   n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input string n, input int ar, input int ai, input int br,
                              input int bi, input int wr, input int wi, input bit sc,
                              input bit inv, input int x0r, input int x0i, input int x1r,
                              input int x1i, input bit ov);
    vec_t v;
    v.name = n; v.ar = ar; v.ai = ai; v.br = br; v.bi = bi; v.wr = wr; v.wi = wi;
    v.sc = sc; v.inv = inv; v.x0r = x0r; v.x0i = x0i; v.x1r = x1r; v.x1i = x1i; v.ov = ov;
    return v;
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive(input vec_t v);
    a_re = 16'(v.ar); a_im = 16'(v.ai); b_re = 16'(v.br); b_im = 16'(v.bi);
    w_re = 16'(v.wr); w_im = 16'(v.wi); scale = v.sc; inverse = v.inv;
  endtask

  // One transfer, then wait (bounded) for out_valid and compare the result.
  task automatic run_vec(input vec_t v);
    int cyc;
    drive(v);
    in_valid = 1'b1;
    cyc = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc++;
    end while (!out_valid && cyc < 10);
    chk({v.name, "_latency"}, cyc, 3);
    chk({v.name, "_x0re"}, X0_re, v.x0r);
    chk({v.name, "_x0im"}, X0_im, v.x0i);
    chk({v.name, "_x1re"}, X1_re, v.x1r);
    chk({v.name, "_x1im"}, X1_im, v.x1i);
    chk({v.name, "_ovf"}, ovf, v.ov);
  endtask

  initial begin
    int   sent, recv, held;
    bit   stalled_prev;
    bit   bad;
    vec_t sv;

    vecs[0] = mk("w_neg1",     10, 3, 4, -1, -32768, 0, 0, 0,  6, 4, 14, 2, 0);
    vecs[1] = mk("w_negj",     10, 3, 4, -1, 0, -32768, 0, 0,  9, -1, 11, 7, 0);
    vecs[2] = mk("w_negj_inv", 10, 3, 4, -1, 0, -32768, 0, 1, 11, 7, 9, -1, 0);
    vecs[3] = mk("scale_small",10, 3, 4, -1, -32768, 0, 1, 0,  3, 2, 7, 1, 0);
    vecs[4] = mk("w_half",     10, 3, 4, -1, 16384, 0, 0, 0, 12, 3, 8, 3, 0);
    vecs[5] = mk("neg_round",  -5, 0, 0, 0, 0, 0, 1, 0,       -2, 0, -2, 0, 0);
    vecs[6] = mk("big_scaled", 32767, 0, 32767, 0, -32768, 0, 1, 0, 0, 0, 32767, 0, 0);
    vecs[7] = mk("neg_ovf",   -32768, 0, -32768, 0, -32768, 0, 0, 0, 0, 0, NEG_X1, 0, 1);
    vecs[8] = mk("pos_ovf",    32767, 0, 32767, 0, -32768, 0, 0, 0, 0, 0, POS_X1, 0, 1);

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_x0re", X0_re, 0);
    chk("rst_x1im", X1_im, 0);
    chk("rst_in_ready", in_ready, 1);

    foreach (vecs[i]) begin
      do_reset();
      run_vec(vecs[i]);
    end

    // Overflow must persist through a later in-range result.
    sv = vecs[0];
    sv.name = "sticky";
    sv.ov = 1'b1;
    run_vec(sv);

    // Eight back-to-back samples with out_ready dropped for two cycles.
    do_reset();
    sv = mk("stream", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive(sv);
    sent = 0; recv = 0; held = 0; stalled_prev = 1'b0;
    for (int c = 0; c < 40 && recv < 8; c++) begin
      out_ready = !(c == 5 || c == 6);
      if (sent < 8) begin
        in_valid = 1'b1;
        a_re = 16'(100 * (sent + 1));
        a_im = 16'(sent + 1);
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("stream_in_ready", in_ready, (out_valid && !out_ready) ? 0 : 1);
      if (stalled_prev) chk("stream_held_x0re", X0_re, held);
      stalled_prev = out_valid && !out_ready;
      held = X0_re;
      if (out_valid && out_ready) begin
        chk("stream_x0re", X0_re, 100 * (recv + 1));
        chk("stream_x1im", X1_im, recv + 1);
        recv++;
      end
      if (in_valid && in_ready) sent++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    chk("stream_count", recv, 8);
    bad = 1'b0;
    repeat (4) begin
      if (out_valid) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("stream_no_dup", bad, 0);

    // Reset with two samples in flight (first one overflows).
    drive(vecs[8]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    drive(vecs[0]);
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_x0re", X0_re, 0);
    chk("midrst_x1re", X1_re, 0);
    chk("midrst_ovf", ovf, 0);
    chk("midrst_in_ready", in_ready, 1);
    bad = 1'b0;
    repeat (6) begin
      if (out_valid || ovf) bad = 1'b1;
      @(posedge clk); #1;
    end
    chk("midrst_no_stale", bad, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fft_bfly_r2.md
FFT_BFLY_R2 -- requirements
Module: fft_bfly_r2

Interface
REQ-001 Parameter DW, default 16: signed data width of a, b and X ports.
REQ-002 Parameter TW, default 16: signed twiddle width, Q1.(TW-1); -2^(TW-1) represents -1.0.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  reset is synchronous and active-high.
REQ-005 in_valid  in  1  input sample pair valid.
REQ-006 in_ready  out  1  block can accept input this cycle.
REQ-007 scale  in  1  1 = divide both outputs by 2 with rounding; sampled with the input.
REQ-008 inverse  in  1  1 = use conj(W); sampled with the input.
REQ-009 a_re, a_im, b_re, b_im  in  DW each  signed input operands.
REQ-010 w_re, w_im  in  TW each  signed twiddle.
REQ-011 out_valid  out  1  result valid.
REQ-012 out_ready  in  1  downstream accepts result.
REQ-013 X0_re, X0_im, X1_re, X1_im  out  DW each  X0 = a + W*b, X1 = a - W*b.
REQ-014 ovf  out  1  sticky flag: some result exceeded DW range.

Function
REQ-015 The block SHALL be a 3-stage pipeline: input register, complex multiply, add/subtract/scale.
REQ-016 Stall rule: en = !out_valid | out_ready; in_ready SHALL equal en; no stage advances while en = 0.
REQ-017 Transfer occurs when in_valid & in_ready; its result SHALL appear with out_valid = 1 exactly 3 cycles later when never stalled.
REQ-018 Throughput SHALL be one transfer per cycle with out_ready held high; no bubbles are inserted.
REQ-019 Held results (out_valid & !out_ready) SHALL keep all X outputs stable until accepted.
REQ-020 Simultaneous acceptance of the output and a new input SHALL lose no sample.
REQ-021 With inverse = 1, w_im SHALL be negated in TW+1 bits, so -(-2^(TW-1)) is exact.
REQ-022 p_re = (b_re*w_re - b_im*w_im + 2^(TW-2)) >>> (TW-1); p_im = (b_re*w_im + b_im*w_re + 2^(TW-2)) >>> (TW-1).
REQ-023 Products SHALL be computed at full width with no intermediate overflow.
REQ-024 Sums s0 = a + p and s1 = a - p SHALL be formed at DW+2 bits.
REQ-025 When scale = 1, each sum SHALL be replaced by (s + 1) >>> 1 before range reduction.
REQ-026 A value outside [-2^(DW-1), 2^(DW-1)-1] SHALL set ovf in the cycle its result becomes valid.
REQ-027 ovf SHALL stay set until reset.
REQ-028 scale and inverse SHALL travel with their sample through the pipeline.

Reset
REQ-029 While rst = 1 at a rising edge, all stage valid bits, out_valid, ovf and all X outputs SHALL be cleared to 0.
REQ-030 in_ready SHALL be 1 in the cycle after reset.
REQ-031 Reset asserted mid-operation SHALL discard every in-flight sample; none SHALL emerge afterwards.

Configuration
REQ-032 With FFT_BFLY_SAT_EN defined, out-of-range results SHALL saturate to 2^(DW-1)-1 or -2^(DW-1).
REQ-033 Without FFT_BFLY_SAT_EN, out-of-range results SHALL wrap (keep the low DW bits).
REQ-034 ovf SHALL behave identically in both builds.

Verification (DW = TW = 16)
REQ-035 a=10+j3, b=4-j1, w=(-32768,0), scale=0, inverse=0 -> 3 cycles later X0=6+j4, X1=14+j2, ovf=0.
REQ-036 Same a, b; w=(0,-32768); inverse=0 -> X0=9-j1, X1=11+j7; with inverse=1 -> X0=11+j7, X1=9-j1.
REQ-037 a_re=32767, b_re=32767, other parts 0, w=(-32768,0), scale=0 -> X1_re=32767 with SAT_EN, -2 without; ovf=1 in both.
REQ-038 Same inputs with scale=1 -> X1_re=32767, X0_re=0, ovf stays 0 after reset.
REQ-039 Stream 8 back-to-back samples; out_ready low for 2 cycles mid-stream -> 8 results in order, none lost or duplicated, in_ready low only while stalled.
REQ-040 Assert rst for 1 cycle with 2 samples in flight -> out_valid=0, outputs=0, ovf=0, and no stale result appears afterwards.
